// File: rtl/agc_gain_ctrl.sv
// AGC gain sequencer: settles, measures EMA power error, applies a scaled
// and clamped gain step, and tracks lock across consecutive small errors.
module agc_gain_ctrl #(
  parameter int W_PWR      = 16,
  parameter int F_PWR      = 14,
  parameter int W_ALPHA    = 16,
  parameter int F_ALPHA    = 14,
  parameter int W_GAIN     = 10,
  parameter int F_GAIN     = 6,
  parameter int GAIN_INIT  = 64,
  parameter int GAIN_MIN   = 1,
  parameter int GAIN_MAX   = 1023,
  parameter int SETTLE_LEN = 16,
  parameter int LOCK_TOL   = 256,
  parameter int LOCK_CNT   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic               i_freeze,
  input  logic [W_ALPHA-1:0] i_alpha,
  input  logic [W_PWR-1:0]   i_reference,
  input  logic [W_PWR-1:0]   i_power,
  input  logic               i_power_valid,
  output logic [W_GAIN-1:0]  o_gain,
  output logic               o_gain_valid,
  output logic               o_locked,
  output logic [2:0]         o_state
);

  // state   | meaning
  // IDLE    | loop disabled, gain held
  // SETTLE  | discarding power samples after a gain change
  // MEASURE | waiting for the power sample to capture as error
  // CALC    | registering error * alpha
  // APPLY   | writing the clamped gain and updating lock
  // HOLD    | frozen, gain and lock held
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_CALC    = 3'd3,
    S_APPLY   = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam int W_ERR  = W_PWR + 1;
  localparam int W_PROD = W_PWR + 1 + W_ALPHA;
  localparam int SHIFT  = F_PWR + F_ALPHA - F_GAIN;
  localparam int W_SUM  = W_PROD + 1;
  localparam int W_SCNT = $clog2(SETTLE_LEN + 1);
  localparam int W_LCNT = $clog2(LOCK_CNT + 1);

  localparam logic [W_SCNT-1:0] SETTLE_RELOAD = W_SCNT'(SETTLE_LEN);
  localparam logic [W_LCNT-1:0] LOCK_FULL     = W_LCNT'(LOCK_CNT);
  localparam logic [W_LCNT-1:0] LOCK_LAST     = W_LCNT'(LOCK_CNT - 1);
  localparam logic [W_ERR-1:0]  TOL           = W_ERR'(LOCK_TOL);
  localparam logic [W_GAIN-1:0] G_INIT        = W_GAIN'(GAIN_INIT);
  localparam logic [W_GAIN-1:0] G_MIN         = W_GAIN'(GAIN_MIN);
  localparam logic [W_GAIN-1:0] G_MAX         = W_GAIN'(GAIN_MAX);
  localparam logic signed [W_SUM-1:0] SUM_MIN = $signed(W_SUM'(GAIN_MIN));
  localparam logic signed [W_SUM-1:0] SUM_MAX = $signed(W_SUM'(GAIN_MAX));

  state_t                     state;
  logic [W_SCNT-1:0]          settle_cnt;
  logic [W_LCNT-1:0]          lock_cnt;
  logic signed [W_ERR-1:0]    err_q;
  logic signed [W_PROD-1:0]   prod_q;
  logic                       freeze_pend;

  logic signed [W_ERR-1:0]    err_next;
  logic signed [W_PROD-1:0]   prod_next;
  logic signed [W_PROD-1:0]   delta;
  logic signed [W_SUM-1:0]    sum;
  logic [W_GAIN-1:0]          gain_next;
  logic [W_ERR-1:0]           err_abs;
  logic                       in_tol;

  assign err_next = $signed({1'b0, i_reference}) - $signed({1'b0, i_power});

  // Operands widened to the product width; |err| * alpha always fits in W_PROD signed bits.
  assign prod_next = $signed({{W_ALPHA{err_q[W_ERR-1]}}, err_q})
                   * $signed({{W_ERR{1'b0}}, i_alpha});

  assign delta = prod_q >>> SHIFT;
  assign sum   = $signed({{(W_SUM - W_GAIN){1'b0}}, o_gain})
               + $signed({delta[W_PROD-1], delta});

  always_comb begin
    gain_next = sum[W_GAIN-1:0];
    if (sum < SUM_MIN)
      gain_next = G_MIN;
    else if (sum > SUM_MAX)
      gain_next = G_MAX;
  end

  assign err_abs = err_q[W_ERR-1] ? W_ERR'(-err_q) : W_ERR'(err_q);
  assign in_tol  = (err_abs <= TOL);
  assign o_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      lock_cnt     <= '0;
      err_q        <= '0;
      prod_q       <= '0;
      freeze_pend  <= 1'b0;
      o_gain       <= G_INIT;
      o_gain_valid <= 1'b0;
      o_locked     <= 1'b0;
    end else begin
      o_gain_valid <= 1'b0;
      if (!i_enable) begin
        state       <= S_IDLE;
        settle_cnt  <= '0;
        lock_cnt    <= '0;
        o_locked    <= 1'b0;
        freeze_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_RELOAD;
          end
          S_SETTLE: begin
            if (i_freeze) begin
              state <= S_HOLD;
            end else if (i_power_valid) begin
              if (settle_cnt <= W_SCNT'(1)) begin
                settle_cnt <= '0;
                state      <= S_MEASURE;
              end else begin
                settle_cnt <= settle_cnt - 1'b1;
              end
            end
          end
          S_MEASURE: begin
            if (i_freeze) begin
              state <= S_HOLD;
            end else if (i_power_valid) begin
              err_q <= err_next;
              state <= S_CALC;
            end
          end
          S_CALC: begin
            prod_q      <= prod_next;
            freeze_pend <= i_freeze;
            state       <= S_APPLY;
          end
          S_APPLY: begin
            o_gain       <= gain_next;
            o_gain_valid <= 1'b1;
            if (in_tol) begin
              if (lock_cnt < LOCK_FULL)
                lock_cnt <= lock_cnt + 1'b1;
              if (lock_cnt >= LOCK_LAST)
                o_locked <= 1'b1;
            end else begin
              lock_cnt <= '0;
              o_locked <= 1'b0;
            end
            // A freeze seen during the update is honoured once the write lands.
            freeze_pend <= 1'b0;
            if (i_freeze || freeze_pend) begin
              state <= S_HOLD;
            end else begin
              state      <= S_SETTLE;
              settle_cnt <= SETTLE_RELOAD;
            end
          end
          S_HOLD: begin
            if (!i_freeze) begin
              state      <= S_SETTLE;
              settle_cnt <= SETTLE_RELOAD;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed-plus-random bench for agc_gain_ctrl against an arithmetic model
// of the gain update and lock rules.
module tb_agc_gain_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic        i_freeze;
  logic [15:0] i_alpha;
  logic [15:0] i_reference;
  logic [15:0] i_power;
  logic        i_power_valid;
  logic [9:0]  o_gain;
  logic        o_gain_valid;
  logic        o_locked;
  logic [2:0]  o_state;

  int n_checks = 0;
  int n_errors = 0;

  int m_gain   = 64;
  int m_lock   = 0;
  int m_locked = 0;

  always #5 clk = ~clk;

  agc_gain_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_freeze     (i_freeze),
    .i_alpha      (i_alpha),
    .i_reference  (i_reference),
    .i_power      (i_power),
    .i_power_valid(i_power_valid),
    .o_gain       (o_gain),
    .o_gain_valid (o_gain_valid),
    .o_locked     (o_locked),
    .o_state      (o_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gain rule: floor(err*alpha / 2^22), added to gain and clamped to [1,1023].
  task automatic model_update(input int pw, input int rf, input int al);
    longint err, p, d, q;
    int g;
    err = longint'(rf) - longint'(pw);
    p = err * longint'(al);
    d = longint'(1) << 22;
    q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    g = m_gain + int'(q);
    if (g < 1) g = 1;
    if (g > 1023) g = 1023;
    m_gain = g;
    if ((err < 0 ? -err : err) <= 256) begin
      if (m_lock < 4) m_lock++;
    end else begin
      m_lock = 0;
    end
    m_locked = (m_lock == 4) ? 1 : 0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      i_power = 16'($urandom);
      i_power_valid = 1'b1;
      tick();
      i_power_valid = 1'b0;
    end
  endtask

  task automatic measure_apply(input int pw, input int rf, input int al);
    int g_old;
    int stray;
    g_old = m_gain;
    stray = $urandom_range(0, 1);
    check("measure_state", o_state, 2);
    i_power = 16'(pw);
    i_reference = 16'(rf);
    i_alpha = 16'(al);
    i_power_valid = 1'b1;
    tick();
    // Optional stray valids in CALC and APPLY must not count toward settle.
    i_power_valid = stray[0];
    i_reference = 16'($urandom);
    check("calc_state", o_state, 3);
    check("calc_gain", o_gain, g_old);
    tick();
    i_alpha = 16'($urandom);
    check("apply_state", o_state, 4);
    check("apply_valid", o_gain_valid, 0);
    tick();
    i_power_valid = 1'b0;
    model_update(pw, rf, al);
    check("upd_gain", o_gain, m_gain);
    check("upd_valid", o_gain_valid, 1);
    check("upd_locked", o_locked, m_locked);
    check("upd_state", o_state, 1);
    tick();
    check("valid_pulse", o_gain_valid, 0);
  endtask

  task automatic update(input int pw, input int rf, input int al);
    settle(16);
    measure_apply(pw, rf, al);
  endtask

  initial begin
    int rf, off, g_keep;
    reset = 1'b1;
    i_enable = 1'b0;
    i_freeze = 1'b0;
    i_alpha = '0;
    i_reference = '0;
    i_power = '0;
    i_power_valid = 1'b0;
    #12;
    check("rst_gain", o_gain, 64);
    check("rst_valid", o_gain_valid, 0);
    check("rst_locked", o_locked, 0);
    check("rst_state", o_state, 0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_state", o_state, 0);
    i_enable = 1'b1;
    tick();
    check("enable_state", o_state, 1);

    // Basic step: err=0x2000, alpha=1.0 -> delta 32
    update(16'h2000, 16'h4000, 16'h4000);
    check("step_96", o_gain, 96);

    // Clamp low, then high
    for (int i = 0; i < 3; i++) update(16'h7FFF, 16'h1000, 16'h4000);
    check("clamp_min", o_gain, 1);
    for (int i = 0; i < 3; i++) update(0, 16'hFFFF, 16'hFFFF);
    check("clamp_max", o_gain, 1023);

    // Random updates
    for (int i = 0; i < 8; i++)
      update($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));

    // Lock acquisition and loss
    update(16'hFFFF, 0, 16'h0100);
    check("lock_cleared", o_locked, 0);
    for (int i = 0; i < 4; i++) begin
      rf = $urandom_range(300, 60000);
      off = $urandom_range(0, 512) - 256;
      update(rf + off, rf, $urandom_range(0, 16'h2000));
      if (i == 2) check("lock_3rd", o_locked, 0);
    end
    check("lock_4th", o_locked, 1);
    rf = $urandom_range(2000, 60000);
    update(rf - 1000, rf, 16'h0040);
    check("lock_lost", o_locked, 0);

    // Freeze coinciding with the measurement valid
    settle(16);
    check("frz_measure", o_state, 2);
    g_keep = m_gain;
    i_freeze = 1'b1;
    i_power = 16'h0000;
    i_reference = 16'hFFFF;
    i_alpha = 16'hFFFF;
    i_power_valid = 1'b1;
    tick();
    i_power_valid = 1'b0;
    check("frz_state", o_state, 5);
    check("frz_gain", o_gain, g_keep);
    settle(3);
    check("frz_hold", o_state, 5);
    check("frz_no_write", o_gain, g_keep);
    i_freeze = 1'b0;
    tick();
    check("frz_release", o_state, 1);
    settle(15);
    check("frz_15", o_state, 1);
    settle(1);
    check("frz_16", o_state, 2);
    measure_apply($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));

    // Relock, then drop enable in CALC
    for (int i = 0; i < 4; i++) begin
      rf = $urandom_range(300, 60000);
      off = $urandom_range(0, 512) - 256;
      update(rf + off, rf, $urandom_range(0, 16'h1000));
    end
    check("relock", o_locked, 1);
    settle(16);
    g_keep = m_gain;
    i_power = 16'h0000;
    i_reference = 16'hFFFF;
    i_alpha = 16'hFFFF;
    i_power_valid = 1'b1;
    tick();
    i_power_valid = 1'b0;
    check("abort_calc", o_state, 3);
    i_enable = 1'b0;
    tick();
    m_lock = 0;
    m_locked = 0;
    check("abort_idle", o_state, 0);
    check("abort_gain", o_gain, g_keep);
    check("abort_locked", o_locked, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_valid", o_gain_valid, 0);
      tick();
    end
    check("abort_gain_kept", o_gain, g_keep);
    i_enable = 1'b1;
    tick();
    check("reenable", o_state, 1);

    // Async reset in the middle of APPLY
    settle(16);
    i_power = 16'h0000;
    i_reference = 16'hFFFF;
    i_alpha = 16'hFFFF;
    i_power_valid = 1'b1;
    tick();
    i_power_valid = 1'b0;
    tick();
    check("pre_rst_apply", o_state, 4);
    #2;
    reset = 1'b1;
    #1;
    m_gain = 64;
    m_lock = 0;
    m_locked = 0;
    check("arst_gain", o_gain, 64);
    check("arst_valid", o_gain_valid, 0);
    check("arst_locked", o_locked, 0);
    check("arst_state", o_state, 0);
    tick();
    reset = 1'b0;
    check("arst_hold_gain", o_gain, 64);
    tick();
    check("arst_settle", o_state, 1);
    settle(16);
    check("arst_16_gain", o_gain, 64);
    measure_apply(16'h2000, 16'h4000, 16'h4000);
    check("arst_17_gain", o_gain, 96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/agc_gain_ctrl.md
Name: agc_gain_ctrl

Overview:
- Closed-loop gain sequencer for the AGC datapath.
- Consumes the EMA power estimate and the reference level, and computes a saturated gain update scaled by the speed coefficient alpha.
- Drives the gain word that multiplies the I/Q samples.
- Sequences the loop with an explicit settle window after each gain change so the EMA output reflects the new gain; reports lock status.

Parameters:
W_PWR, 16, width of power estimate and reference (unsigned)
F_PWR, 14, fractional bits of power/reference
W_ALPHA, 16, width of alpha (unsigned)
F_ALPHA, 14, fractional bits of alpha
W_GAIN, 10, width of gain word (unsigned)
F_GAIN, 6, fractional bits of gain
GAIN_INIT, 64, gain after reset (1.0)
GAIN_MIN, 1, lower clamp
GAIN_MAX, 1023, upper clamp
SETTLE_LEN, 16, power samples discarded after each gain change (>=1)
LOCK_TOL, 256, |error| threshold for lock, power units
LOCK_CNT, 4, consecutive in-tolerance updates to declare lock

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_enable  in  1  loop enable
i_freeze  in  1  hold gain, suspend updates
i_alpha  in  W_ALPHA  loop speed
i_reference  in  W_PWR  target power level
i_power  in  W_PWR  EMA power estimate
i_power_valid  in  1  i_power qualifier, single-cycle pulses
o_gain  out  W_GAIN  gain to datapath multipliers
o_gain_valid  out  1  one-cycle pulse when o_gain changes value or is rewritten
o_locked  out  1  loop locked
o_state  out  3  FSM state code, for debug

Behaviour:
- Reset (async, immediate):
  - o_gain=GAIN_INIT, o_gain_valid=0, o_locked=0, state=IDLE.
  - Settle counter=0, lock counter=0.
- State codes: IDLE=0, SETTLE=1, MEASURE=2, CALC=3, APPLY=4, HOLD=5.
- IDLE: o_gain held. When i_enable=1, go to SETTLE with counter=SETTLE_LEN.
- SETTLE: each i_power_valid decrements the counter. When the counter reaches 0 on a valid, go to MEASURE next cycle.
- MEASURE: on i_power_valid, capture signed error err = i_reference - i_power (W_PWR+1 bits) and go to CALC.
- CALC: product = err * alpha (signed, W_PWR+1+W_ALPHA bits, registered); go to APPLY.
- APPLY:
  - delta = product >>> (F_PWR+F_ALPHA-F_GAIN), arithmetic shift, floor rounding.
  - sum = o_gain + delta, computed in a wide signed width; clamp to [GAIN_MIN, GAIN_MAX].
  - Register o_gain, pulse o_gain_valid for one cycle, go to SETTLE with counter reload.
- Latency: from the edge capturing power in MEASURE to the edge updating o_gain is 2 clocks.
- Lock:
  - In APPLY, if |err| <= LOCK_TOL, increment the lock counter (saturating at LOCK_CNT); otherwise clear it and deassert o_locked.
  - o_locked=1 from the APPLY where the counter reaches LOCK_CNT.
  - Clamping does not by itself affect lock.
- i_power_valid pulses in CALC, APPLY, HOLD and IDLE are ignored and not counted.
- Freeze:
  - i_freeze=1 in SETTLE or MEASURE goes to HOLD next cycle. Freeze wins over a simultaneous i_power_valid.
  - In CALC/APPLY the update completes first; HOLD is entered after APPLY instead of SETTLE.
  - HOLD: o_gain and o_locked held.
  - On i_freeze=0, go to SETTLE with counter reload.
- i_enable=0 in any state:
  - Go to IDLE next cycle, aborting CALC/APPLY without a gain write.
  - o_gain retains its value; o_locked and the lock counter clear.
  - i_enable has priority over i_freeze.
- i_alpha and i_reference are sampled in MEASURE/CALC only; changing them mid-settle is legal.
- alpha=0 gives delta=0; o_gain_valid still pulses.

Test Plan:
- Reset, enable, 16 valid pulses, then power=0x2000, ref=0x4000, alpha=0x4000 -> err=0x2000, delta=32, o_gain 64->96 two clocks after capture, o_gain_valid one cycle, state returns to SETTLE.
- Power=0x7FFF repeatedly, ref=0x1000, alpha=0x4000 -> gain decreases and clamps at 1, never wraps; power=0 repeatedly -> clamps at 1023.
- Power within ±256 of ref for 4 consecutive updates -> o_locked rises on the 4th APPLY; a 5th update with err=1000 -> o_locked falls.
- i_freeze asserted in the same cycle as the MEASURE valid -> no capture, state=HOLD, gain unchanged; release -> exactly 16 valids before the next MEASURE.
- i_enable dropped while in CALC -> no o_gain_valid, IDLE next cycle, gain retained, o_locked=0.
- Async reset asserted mid-APPLY, between clock edges -> outputs return to reset values immediately; 17 valids after re-enable needed before a gain update.
